// File: rtl/axi_aw_grant_lock.sv
// axi_aw_grant_lock: holds the arbiter's one-hot grant for a full AXI write (AW, W burst, B)
// and routes the handshakes between the granted master and the slave port.
module axi_aw_grant_lock #(
   parameter int NM      = 6,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [NM-1:0] m_sel,
   input  logic [NM-1:0] awvalid,
   output logic [NM-1:0] awready,
   input  logic [NM-1:0] wvalid,
   input  logic [NM-1:0] wlast,
   output logic [NM-1:0] wready,
   output logic [NM-1:0] bvalid,
   input  logic [NM-1:0] bready,
   output logic          awvalid_s,
   input  logic          awready_s,
   output logic          wvalid_s,
   output logic          wlast_s,
   input  logic          wready_s,
   input  logic          bvalid_s,
   output logic          bready_s,
   output logic [NM-1:0] grant,
   output logic          busy,
   output logic          done,
   output logic [7:0]    beats,
   output logic [1:0]    err
);
   localparam int WW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
   typedef enum logic [1:0] {IDLE, AW, W, B} state_t;
   state_t state, state_nx;
   logic [WW-1:0] wd, wd_inc;
   logic one_hot, multi, take, aw_hs, w_hs, b_hs, hs, tmo;
   assign multi   = (m_sel & (m_sel - NM'(1))) != '0;
   assign one_hot = m_sel != '0 && !multi;
   assign take    = state == IDLE && one_hot && |(m_sel & awvalid);
   assign awvalid_s = state == AW && |(awvalid & grant);
   assign awready   = (state == AW && awready_s) ? grant : '0;
   assign wvalid_s  = state == W && |(wvalid & grant);
   assign wlast_s   = state == W && |(wlast & grant);
   assign wready    = (state == W && wready_s) ? grant : '0;
   assign bvalid    = (state == B && bvalid_s) ? grant : '0;
   assign bready_s  = state == B && |(bready & grant);
   assign busy      = state != IDLE;
   assign aw_hs = awvalid_s & awready_s;
   assign w_hs  = wvalid_s & wready_s;
   assign b_hs  = bvalid_s & bready_s;
   assign hs    = aw_hs | w_hs | b_hs;
   assign wd_inc = wd + WW'(1);
   // Watchdog fires on the cycle whose stall would bring the count to TIMEOUT.
   assign tmo = TIMEOUT > 0 && busy && !hs && wd_inc == WW'(TIMEOUT);
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: state_nx = take ? AW : IDLE;
         AW:   state_nx = aw_hs ? W : AW;
         W:    state_nx = (w_hs && wlast_s) ? B : W;
         B:    state_nx = b_hs ? IDLE : B;
      endcase
      if (tmo) state_nx = IDLE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         grant <= '0;
         beats <= '0;
         err   <= '0;
         done  <= 1'b0;
         wd    <= '0;
      end else begin
         state <= state_nx;
         done  <= b_hs;
         if (take) grant <= m_sel;
         else if (tmo || b_hs) grant <= '0;
         if (take) beats <= '0;
         else if (w_hs && beats != 8'hFF) beats <= beats + 8'd1;
         if (state == IDLE && multi) err[0] <= 1'b1;
         if (tmo) err[1] <= 1'b1;
         wd <= (hs || !busy || state_nx != state) ? '0 : wd_inc;
      end
   end
endmodule

// File: tb/tb_axi_aw_grant_lock.sv
// tb_axi_aw_grant_lock: randomized and directed checks of the write-grant lock against a
// transaction-level model of the AW/W/B sequence.
module tb_axi_aw_grant_lock;
   localparam int NM = 6;
   logic clk, rst_n;
   logic [NM-1:0] m_sel, awvalid, awready, wvalid, wlast, wready, bvalid, bready, grant;
   logic awvalid_s, awready_s, wvalid_s, wlast_s, wready_s, bvalid_s, bready_s, busy, done;
   logic [7:0] beats;
   logic [1:0] err, exp_err;
   logic [3*NM+3:0] route;
   int passed = 0, total = 0;

   axi_aw_grant_lock #(.NM(NM), .TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n), .m_sel(m_sel), .awvalid(awvalid), .awready(awready),
      .wvalid(wvalid), .wlast(wlast), .wready(wready), .bvalid(bvalid), .bready(bready),
      .awvalid_s(awvalid_s), .awready_s(awready_s), .wvalid_s(wvalid_s), .wlast_s(wlast_s),
      .wready_s(wready_s), .bvalid_s(bvalid_s), .bready_s(bready_s), .grant(grant),
      .busy(busy), .done(done), .beats(beats), .err(err)
   );

   assign route = {awvalid_s, wvalid_s, wlast_s, bready_s, awready, wready, bvalid};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] sat(input int n);
      return n > 255 ? 8'd255 : 8'(n);
   endfunction

   task automatic clear_inputs;
      m_sel = '0; awvalid = '0; wvalid = '0; wlast = '0; bready = '0;
      awready_s = 1'b0; wready_s = 1'b0; bvalid_s = 1'b0;
   endtask

   // One full transaction for master m with random stalls and noise on the unrouted bits.
   task automatic do_txn(input int m, input int len, input bit req, input bit rnd_sel,
                         input logic [NM-1:0] busy_sel, input logic [NM-1:0] sel_after);
      logic [NM-1:0] oh;
      logic [3*NM+3:0] er;
      int ph, bc, st, cyc;
      bit hs, fin;
      oh = NM'(1) << m;
      if (req) begin
         @(negedge clk);
         clear_inputs();
         m_sel = oh;
         awvalid = oh;
      end
      ph = 1; bc = 0; st = 0; cyc = 0; fin = 0;
      while (!fin && cyc < len * 8 + 64) begin
         @(negedge clk);
         cyc++;
         m_sel = rnd_sel ? NM'($urandom) : busy_sel;
         awvalid = NM'($urandom); wvalid = NM'($urandom); wlast = NM'($urandom);
         bready = NM'($urandom);
         awready_s = 1'($urandom); wready_s = 1'($urandom); bvalid_s = 1'($urandom);
         wlast[m] = (bc == len - 1);
         if (st >= 4) begin
            awvalid[m] = 1'b1; wvalid[m] = 1'b1; bready[m] = 1'b1;
            awready_s = 1'b1; wready_s = 1'b1; bvalid_s = 1'b1;
         end
         #1;
         hs = ph == 1 ? (awvalid[m] & awready_s) : ph == 2 ? (wvalid[m] & wready_s) : (bvalid_s & bready[m]);
         er = {ph == 1 && awvalid[m] == 1'b1, ph == 2 && wvalid[m] == 1'b1, ph == 2 && wlast[m] == 1'b1,
               ph == 3 && bready[m] == 1'b1, (ph == 1 && awready_s) ? oh : NM'(0),
               (ph == 2 && wready_s) ? oh : NM'(0), (ph == 3 && bvalid_s) ? oh : NM'(0)};
         total++; if (grant !== oh) $display("FAIL txn_grant m%0d: got %b want %b", m, grant, oh); else passed++;
         total++; if ({busy, done} !== 2'b10) $display("FAIL txn_busy_done m%0d: got %b want 10", m, {busy, done}); else passed++;
         total++; if (beats !== sat(bc)) $display("FAIL txn_beats m%0d: got %0d want %0d", m, beats, sat(bc)); else passed++;
         total++; if (route !== er) $display("FAIL txn_route m%0d ph%0d: got %b want %b", m, ph, route, er); else passed++;
         if (hs) begin
            st = 0;
            if (ph == 1) ph = 2;
            else if (ph == 2) begin
               bc++;
               if (wlast[m]) ph = 3;
            end else fin = 1;
         end else st++;
      end
      if (!fin) begin
         total++;
         $display("FAIL txn_budget m%0d: got no B handshake in %0d cycles want completion", m, cyc);
      end
      @(negedge clk);
      clear_inputs();
      m_sel = sel_after;
      awvalid = sel_after;
      #1;
      total++; if ({done, busy, grant} !== {1'b1, 1'b0, NM'(0)}) $display("FAIL txn_end m%0d: got done=%b busy=%b grant=%b want 1 0 0", m, done, busy, grant); else passed++;
      total++; if (beats !== sat(bc)) $display("FAIL txn_end_beats m%0d: got %0d want %0d", m, beats, sat(bc)); else passed++;
      total++; if (err !== exp_err) $display("FAIL txn_err m%0d: got %b want %b", m, err, exp_err); else passed++;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      clear_inputs();
      exp_err = 2'b00;
      repeat (2) @(negedge clk);
      m_sel = 6'b000001; awvalid = '1; awready_s = 1'b1; bvalid_s = 1'b1; wready_s = 1'b1;
      #1;
      total++; if ({grant, busy, done, beats, err} !== '0) $display("FAIL reset_regs: got %b want 0", {grant, busy, done, beats, err}); else passed++;
      total++; if (route !== '0) $display("FAIL reset_route: got %b want 0", route); else passed++;
      @(negedge clk);
      total++; if (grant !== '0) $display("FAIL reset_hold_grant: got %b want 0", grant); else passed++;
      clear_inputs();
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      total++; if ({busy, err} !== 3'b000) $display("FAIL reset_release: got %b want 000", {busy, err}); else passed++;
   endtask

   task automatic test_single;
      @(negedge clk);
      m_sel = 6'b000100; awvalid = 6'b000100;
      @(negedge clk);
      #1;
      total++; if (grant !== 6'b000100) $display("FAIL single_grant: got %b want 000100", grant); else passed++;
      total++; if ({busy, awvalid_s, awready} !== {2'b11, 6'b0}) $display("FAIL single_aw_wait: got %b want 11000000", {busy, awvalid_s, awready}); else passed++;
      m_sel = '0; awready_s = 1'b1;
      #1;
      total++; if (awready !== 6'b000100) $display("FAIL single_awready: got %b want 000100", awready); else passed++;
      @(negedge clk);
      awready_s = 1'b0; awvalid = '0; wvalid = 6'b000100; wlast = 6'b000100; wready_s = 1'b1;
      #1;
      total++; if ({wready, wvalid_s, wlast_s, awready} !== {6'b000100, 2'b11, 6'b0}) $display("FAIL single_w: got %b want 00010011000000", {wready, wvalid_s, wlast_s, awready}); else passed++;
      @(negedge clk);
      wvalid = '0; wlast = '0; wready_s = 1'b0; bvalid_s = 1'b1; bready = 6'b000100;
      #1;
      total++; if ({bvalid, bready_s, done, beats} !== {6'b000100, 2'b10, 8'd1}) $display("FAIL single_b: got %b want 000100 1 0 00000001", {bvalid, bready_s, done, beats}); else passed++;
      @(negedge clk);
      clear_inputs();
      #1;
      total++; if ({done, busy, grant, beats} !== {2'b10, 6'b0, 8'd1}) $display("FAIL single_done: got %b want 10 000000 00000001", {done, busy, grant, beats}); else passed++;
      @(negedge clk);
      #1;
      total++; if ({done, grant} !== 7'b0) $display("FAIL single_done_pulse: got %b want 0", {done, grant}); else passed++;
   endtask

   task automatic test_burst_stall;
      logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      int cnt = 0;
      @(negedge clk);
      m_sel = 6'b000100; awvalid = 6'b111111;
      @(negedge clk);
      m_sel = 6'b001000; awready_s = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         awready_s = 1'b0; awvalid = '0;
         wvalid = 6'b111111; wready_s = pat[i]; wlast = (i == 5) ? 6'b111111 : 6'b111011;
         #1;
         total++; if (wready !== (pat[i] ? 6'b000100 : 6'b0)) $display("FAIL burst_wready beat%0d: got %b want %b", i, wready, pat[i] ? 6'b000100 : 6'b0); else passed++;
         total++; if ({busy, bvalid, beats} !== {1'b1, 6'b0, 8'(cnt)}) $display("FAIL burst_state beat%0d: got %b want %b", i, {busy, bvalid, beats}, {1'b1, 6'b0, 8'(cnt)}); else passed++;
         total++; if (wlast_s !== (i == 5)) $display("FAIL burst_wlast beat%0d: got %b want %b", i, wlast_s, i == 5); else passed++;
         if (pat[i]) cnt++;
      end
      @(negedge clk);
      wvalid = '0; wlast = '0; wready_s = 1'b0; bvalid_s = 1'b1; bready = 6'b000100;
      #1;
      total++; if ({bready_s, beats} !== {1'b1, 8'd4}) $display("FAIL burst_b: got %b want 1 00000100", {bready_s, beats}); else passed++;
      @(negedge clk);
      clear_inputs();
      #1;
      total++; if ({done, beats} !== {1'b1, 8'd4}) $display("FAIL burst_done: got %b want 1 00000100", {done, beats}); else passed++;
   endtask

   task automatic test_lock_hold;
      do_txn(0, 3, 1'b1, 1'b0, 6'b100000, 6'b100000);
      do_txn(5, 2, 1'b0, 1'b1, '0, '0);
   endtask

   task automatic test_random;
      for (int t = 0; t < 15; t++)
         do_txn(int'($urandom_range(0, NM - 1)), int'($urandom_range(1, 10)), 1'b1, 1'b1, '0, '0);
   endtask

   task automatic test_saturate;
      do_txn(4, 300, 1'b1, 1'b1, '0, '0);
   endtask

   task automatic test_bad_select;
      @(negedge clk);
      m_sel = 6'b000011; awvalid = '1;
      @(negedge clk);
      #1;
      exp_err = 2'b01;
      total++; if (err !== exp_err) $display("FAIL bad_sel_err: got %b want %b", err, exp_err); else passed++;
      total++; if ({grant, busy} !== 7'b0) $display("FAIL bad_sel_nogrant: got %b want 0", {grant, busy}); else passed++;
      clear_inputs();
      @(negedge clk);
      #1;
      total++; if ({err, busy} !== {exp_err, 1'b0}) $display("FAIL bad_sel_sticky: got %b want %b", {err, busy}, {exp_err, 1'b0}); else passed++;
   endtask

   task automatic test_timeout;
      @(negedge clk);
      m_sel = 6'b000010; awvalid = 6'b000010;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         m_sel = '0; awready_s = 1'b0;
         #1;
         total++; if ({busy, err[1], done} !== 3'b100) $display("FAIL timeout_wait cyc%0d: got %b want 100", k, {busy, err[1], done}); else passed++;
      end
      exp_err = exp_err | 2'b10;
      @(negedge clk);
      #1;
      total++; if ({err, busy, done, grant} !== {exp_err, 2'b00, 6'b0}) $display("FAIL timeout_fire: got %b want %b", {err, busy, done, grant}, {exp_err, 2'b00, 6'b0}); else passed++;
      clear_inputs();
      repeat (2) begin
         @(negedge clk);
         #1;
         total++; if ({done, busy} !== 2'b00) $display("FAIL timeout_nodone: got %b want 00", {done, busy}); else passed++;
      end
   endtask

   task automatic test_reset_mid_burst;
      @(negedge clk);
      m_sel = 6'b001000; awvalid = 6'b001000;
      @(negedge clk);
      m_sel = '0; awready_s = 1'b1;
      @(negedge clk);
      awready_s = 1'b0; awvalid = '0; wvalid = 6'b001000; wready_s = 1'b1;
      @(negedge clk);
      #1;
      total++; if ({beats, grant} !== {8'd1, 6'b001000}) $display("FAIL midrst_pre: got %b want 00000001 001000", {beats, grant}); else passed++;
      rst_n = 1'b0;
      #1;
      total++; if ({grant, busy, done, beats, err} !== '0) $display("FAIL midrst_regs: got %b want 0", {grant, busy, done, beats, err}); else passed++;
      total++; if (route !== '0) $display("FAIL midrst_route: got %b want 0", route); else passed++;
      @(negedge clk);
      clear_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      exp_err = 2'b00;
      @(negedge clk);
      #1;
      total++; if ({busy, err, grant, done} !== '0) $display("FAIL midrst_after: got %b want 0", {busy, err, grant, done}); else passed++;
      do_txn(1, 3, 1'b1, 1'b1, '0, '0);
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst_stall();
      test_lock_hold();
      test_random();
      test_saturate();
      test_bad_select();
      test_timeout();
      test_reset_mid_burst();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/axi_aw_grant_lock.md
Name: axi_aw_grant_lock

Overview:
- Downstream stage of the write-address arbiter. Consumes its one-hot master select and locks the grant for one complete AXI write transaction: AW handshake, W burst up to WLAST, then B response.
- Routes the valid/ready/last handshakes between the granted master and the single slave port.
- Reports busy, done and error status to the top-level wrapper.

Parameters:
- NM, 6, number of masters; width of all per-master vectors.
- TIMEOUT, 255, stall-watchdog limit in cycles without a handshake; 0 disables the watchdog.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- m_sel  input  NM  one-hot grant request from the arbiter; all-zero means no request
- awvalid  input  NM  per-master AWVALID
- awready  output  NM  per-master AWREADY
- wvalid  input  NM  per-master WVALID
- wlast  input  NM  per-master WLAST
- wready  output  NM  per-master WREADY
- bvalid  output  NM  per-master BVALID
- bready  input  NM  per-master BREADY
- awvalid_s  output  1  slave AWVALID
- awready_s  input  1  slave AWREADY
- wvalid_s  output  1  slave WVALID
- wlast_s  output  1  slave WLAST
- wready_s  input  1  slave WREADY
- bvalid_s  input  1  slave BVALID
- bready_s  output  1  slave BREADY
- grant  output  NM  registered locked grant, one-hot or zero
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse on B handshake
- beats  output  8  W beats in the current or most recent burst, saturating at 255
- err  output  2  sticky flags: bit0 = non-one-hot m_sel seen; bit1 = watchdog timeout

Behaviour:
- Reset:
  - rst_n low asynchronously forces state IDLE and clears grant, beats, err, done and the watchdog counter.
  - All outputs read 0 while in reset.
  - Reset mid-transaction abandons the transaction; no response is generated.
- States: IDLE, AW, W, B. Only one transaction is in flight; W is accepted only after the AW handshake.
- IDLE:
  - If m_sel is exactly one-hot and awvalid at that index is high, register grant<=m_sel, clear beats and go to AW on the next edge.
  - If m_sel has more than one bit set, set err[0] and stay in IDLE.
  - If m_sel is zero, or the selected awvalid is low, stay in IDLE.
- Routing is combinational and gated by state and grant (idx = bit set in grant):
  - AW: awvalid_s = awvalid[idx]; awready[idx] = awready_s.
  - W: wvalid_s = wvalid[idx]; wlast_s = wlast[idx]; wready[idx] = wready_s.
  - B: bvalid[idx] = bvalid_s; bready_s = bready[idx].
  - Every other bit of every routed vector, and every routed signal outside its state, is 0.
- AW state: the handshake (awvalid_s & awready_s) moves to W on the next edge.
- W state:
  - Each handshake (wvalid_s & wready_s) increments beats, saturating at 255.
  - A handshake with wlast_s high moves to B. A single-beat burst is legal.
- B state: the handshake (bvalid_s & bready_s) moves to IDLE, pulses done for exactly one cycle and clears grant. beats holds its value until the next grant.
- m_sel changes while busy are ignored; the lock holds until B completes.
- A new grant may be taken in the cycle after done; this gives at least one IDLE cycle between transactions.
- Watchdog (TIMEOUT>0):
  - The counter clears on any routed handshake and on entry to a new state.
  - It increments in AW, W and B.
  - Reaching TIMEOUT sets err[1], clears grant, returns to IDLE and does not pulse done.
- err bits clear only on reset.

Test Plan:
- Single beat: m_sel=6'b000100, awvalid[2]=1, awready_s=1, one W beat with wlast, bvalid_s/bready[2] -> grant=000100 one cycle after the request; awready=000100 during AW; done pulses once; beats=1; grant returns to 0.
- 4-beat burst with wready_s stalled 2 cycles on beat 2 -> beats=4; wready routed only to master 2; state stays in W until wlast; no extra beats are counted during the stall.
- Lock hold: while master 0 is busy, m_sel switches to 100000 -> grant stays 000001 until done; master 5 is granted the cycle after done.
- Bad select: m_sel=000011 in IDLE -> err=2'b01; no grant; busy stays 0.
- Timeout with TIMEOUT=8: grant taken, awready_s held 0 -> err[1] set on the 8th stall cycle; busy drops; done stays 0.
- Reset mid-burst: rst_n low during W beat 2 -> all outputs 0 immediately; after release state is IDLE and err=0.
